blink_scan_demux: RTL
=====================

Name: blink_scan_demux

Overview:
- Downstream consumer of the 1 Hz blink generator output.
- Detects each rising edge of the blink signal and advances a lit position across an LED bank, routing the single blink into an N-way one-hot LED pattern.
- Supports wrap-around scanning and bounce ("knight-rider") scanning.
- Sits between the blink generator and the board LED pins in the demux demo.

Parameters:
- NUM_LEDS, 8, number of LED outputs; legal range 2..32; values outside this range are an elaboration error.
- POS_W, $clog2(NUM_LEDS), width of the position index; derived, not overridden.

Ports:
- clk  input  1  system clock, 50 MHz in the demo.
- rst_n  input  1  asynchronous active-low reset.
- blink_in  input  1  level from the blink generator; treated as asynchronous and always synchronized.
- en  input  1  scan enable; when low, LEDs are dark and position is frozen.
- mode  input  1  0 = wrap scan, 1 = bounce scan; sampled only on a step.
- leds  output  NUM_LEDS  registered LED drive; one-hot at pos when active.
- pos  output  POS_W  current lit index.
- step_pulse  output  1  single-cycle strobe on each position advance.

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is asynchronous and active-low. All state clears immediately on rst_n low and is released synchronously to clk.
- Reset values:
  - leds = 0, pos = 0, step_pulse = 0.
  - FSM = IDLE.
  - Synchronizer registers s0, s1, s2 = 0.
- Synchronizer and edge detect:
  - s0 <= blink_in; s1 <= s0; s2 <= s1.
  - rise = s1 & ~s2.
- Latency: pos, leds and step_pulse update on the 2nd clk edge after the edge that first samples blink_in high in s0.
- One step per blink_in rising edge. A held-high or falling blink_in produces no step.
- FSM states: IDLE, FWD, REV.
  - IDLE: leds = 0, pos held.
  - IDLE -> FWD when en = 1. pos is not changed and no step occurs on that transition.
  - Any state -> IDLE when en = 0. This takes priority over a simultaneous rise, which is dropped.
  - FWD on rise:
    - pos < NUM_LEDS-1: pos+1.
    - pos = NUM_LEDS-1 and mode = 0: pos = 0, stay in FWD.
    - pos = NUM_LEDS-1 and mode = 1: pos = NUM_LEDS-2, go to REV.
  - REV on rise:
    - mode = 0: pos+1 (wrapping to 0 at NUM_LEDS-1), go to FWD.
    - mode = 1, pos > 0: pos-1.
    - mode = 1, pos = 0: pos = 1, go to FWD.
- leds (registered):
  - In FWD/REV: leds[i] = (i == pos).
  - In IDLE: leds = 0.
  - leds reflects the new pos on the same edge as the pos update.
- step_pulse is high for exactly the one cycle following a pos update. It is never asserted in IDLE.
- Arithmetic: pos is unsigned, POS_W bits. No value outside 0..NUM_LEDS-1 is ever produced; non-power-of-2 NUM_LEDS wraps explicitly.
- Reset mid-scan: everything returns to reset values at once. After release, the FSM enters FWD from pos 0 on the first cycle with en = 1.

Optional Feature:
- Macro: BLINK_SCAN_DEMUX_TRAIL_EN.
- Defined:
  - Adds a 2-bit free-running counter tcnt and a registered prev_pos, updated with the old pos on each step.
  - In FWD/REV, leds[prev_pos] is additionally driven high when tcnt == 0, giving a 25% duty dim trail. The trail is suppressed when prev_pos == pos.
  - prev_pos resets to 0.
  - tcnt resets to 0 and runs regardless of en.
- Undefined: strict one-hot output, and neither tcnt nor prev_pos exists.

Decomposition:
- Package blink_scan_pkg:
  - Enum scan_state_t {IDLE, FWD, REV}.
  - Localparams MODE_WRAP = 1'b0 and MODE_BOUNCE = 1'b1.
- One sub-module: edge_sync_rise, containing the 3-flop synchronizer plus rise detect (ports clk, rst_n, d, rise). It is reused by other demux demo inputs.

Test Plan:
- Reset/idle: rst_n low, then high with en = 0, then 4 blink_in pulses -> leds = 0, pos = 0, step_pulse never high.
- Wrap (NUM_LEDS = 8, en = 1, mode = 0), 9 blink_in rising edges 100 cycles apart -> pos 1..7,0,1; leds 8'h02 .. 8'h80, 8'h01, 8'h02; each update 2 edges after the s0 sample.
- Bounce (mode = 1), 16 edges from pos 0 -> pos 1..7,6..0,1,2; step_pulse count = 16.
- Mode switch: mode = 1, pos = 5 in REV, set mode = 0, one edge -> pos 6, FSM in FWD.
- Enable/priority: blink_in held high 1000 cycles gives 1 step only. Drop en on the cycle rise is high -> no step, leds = 0; re-raise en -> resume at the frozen pos.
- Async reset mid-scan: pull rst_n low between clocks at pos 4 -> leds, pos and step_pulse = 0 immediately. With TRAIL_EN defined, leds[prev_pos] duty is 25% over 400 cycles.

Source files
------------

// File: rtl/blink_scan_demux_pkg.sv
// rtl/blink_scan_demux_pkg.sv - scan FSM state and mode encodings for blink_scan_demux
package blink_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } scan_state_t;

    localparam logic MODE_WRAP   = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;

endpackage

// File: rtl/blink_scan_demux_if.sv
// rtl/blink_scan_demux_if.sv - blink input, scan controls and LED bank outputs
interface blink_scan_demux_if #(
    parameter int NUM_LEDS = 8
);
    localparam int POS_W = $clog2(NUM_LEDS);

    logic                blink_in;
    logic                en;
    logic                mode;
    logic [NUM_LEDS-1:0] leds;
    logic [POS_W-1:0]    pos;
    logic                step_pulse;

    modport master (
        output blink_in, en, mode,
        input  leds, pos, step_pulse
    );

    modport slave (
        input  blink_in, en, mode,
        output leds, pos, step_pulse
    );
endinterface

// File: rtl/blink_scan_demux_edge_sync_rise.sv
// rtl/blink_scan_demux_edge_sync_rise.sv - 3-flop synchronizer with rising-edge strobe
module edge_sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic s0, s1, s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s0 <= d;
            s1 <= s0;
            s2 <= s1;
        end
    end

    assign rise = s1 & ~s2;
endmodule

// File: rtl/blink_scan_demux.sv
// rtl/blink_scan_demux.sv - steps a lit LED across the bank on each blink rising edge
// Optional dim trail on the previous position: define BLINK_SCAN_DEMUX_TRAIL_EN.
module blink_scan_demux
    import blink_scan_pkg::*;
#(
    parameter  int NUM_LEDS = 8,
    localparam int POS_W    = $clog2(NUM_LEDS)
) (
    input logic               clk,
    input logic               rst_n,
    blink_scan_demux_if.slave bus
);
    if (NUM_LEDS < 2 || NUM_LEDS > 32) begin : g_bad_num_leds
        $error("blink_scan_demux: NUM_LEDS must be within 2..32");
    end

    localparam logic [POS_W-1:0] LAST = POS_W'(NUM_LEDS - 1);

    scan_state_t         state, state_n;
    logic [POS_W-1:0]    pos_q, pos_n;
    logic [NUM_LEDS-1:0] leds_q, leds_n;
    logic                step_q, step_n;
    logic                rise;

    edge_sync_rise u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.blink_in),
        .rise  (rise)
    );

`ifdef BLINK_SCAN_DEMUX_TRAIL_EN
    logic [1:0]       tcnt;
    logic [POS_W-1:0] prev_pos, prev_pos_n;

    assign prev_pos_n = step_n ? pos_q : prev_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt     <= 2'd0;
            prev_pos <= '0;
        end else begin
            tcnt     <= tcnt + 2'd1;
            prev_pos <= prev_pos_n;
        end
    end
`endif

    // Dropping en wins over a coincident rise; that rise is simply lost.
    always_comb begin
        state_n = state;
        pos_n   = pos_q;
        step_n  = 1'b0;
        if (!bus.en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: state_n = FWD;
                FWD: if (rise) begin
                    step_n = 1'b1;
                    if (pos_q != LAST) begin
                        pos_n = pos_q + 1'b1;
                    end else if (bus.mode == MODE_WRAP) begin
                        pos_n = '0;
                    end else begin
                        pos_n   = LAST - 1'b1;
                        state_n = REV;
                    end
                end
                REV: if (rise) begin
                    step_n = 1'b1;
                    if (bus.mode == MODE_WRAP) begin
                        pos_n   = (pos_q == LAST) ? '0 : pos_q + 1'b1;
                        state_n = FWD;
                    end else if (pos_q != '0) begin
                        pos_n = pos_q - 1'b1;
                    end else begin
                        pos_n   = POS_W'(1);
                        state_n = FWD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        leds_n = '0;
        if (state_n != IDLE) begin
            leds_n[pos_n] = 1'b1;
`ifdef BLINK_SCAN_DEMUX_TRAIL_EN
            if (tcnt == 2'd0 && prev_pos_n != pos_n) begin
                leds_n[prev_pos_n] = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pos_q  <= '0;
            leds_q <= '0;
            step_q <= 1'b0;
        end else begin
            state  <= state_n;
            pos_q  <= pos_n;
            leds_q <= leds_n;
            step_q <= step_n;
        end
    end

    assign bus.leds       = leds_q;
    assign bus.pos        = pos_q;
    assign bus.step_pulse = step_q;
endmodule
